// File: rtl/rss_pkg.sv
// rss_pkg: shared types and the immediate sign-extension helper for reg_select_sequencer.
`default_nettype none

package rss_pkg;

  typedef enum logic [1:0] {
    MODE_R  = 2'b00,
    MODE_I  = 2'b01,
    MODE_ST = 2'b10,
    MODE_BR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SRC1 = 2'b01,
    S_SRC2 = 2'b10,
    S_DEST = 2'b11
  } state_e;

  localparam int unsigned SEXT_MAX_W = 64;

  // Callers zero-pad the immediate to SEXT_MAX_W and cast the result down to their bus width.
  function automatic logic [SEXT_MAX_W-1:0] rss_sext(input logic [SEXT_MAX_W-1:0] val,
                                                     input int unsigned imm_w);
    logic [SEXT_MAX_W-1:0] mask;
    logic [SEXT_MAX_W-1:0] sign_bit;
    mask     = {SEXT_MAX_W{1'b1}} << imm_w;
    sign_bit = {{(SEXT_MAX_W-1){1'b0}}, 1'b1} << (imm_w - 1);
    if ((val & sign_bit) != '0)
      rss_sext = val | mask;
    else
      rss_sext = val & ~mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// onehot_decoder: register index to one-hot enable vector, all zeros when disabled.
`default_nettype none

module onehot_decoder #(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic                i_en,
  input  logic [RA_W-1:0]     i_idx,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en)
      o_onehot[i_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/reg_select_sequencer.sv
// reg_select_sequencer: steps IR register fields through SRC1/SRC2/DEST phases with registered enables.
// Optional macro RSS_ZERO_REG_EN makes R0 a hardwired zero (reads become zero_out, writes suppressed).
`default_nettype none

module reg_select_sequencer
  import rss_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RA_W     = $clog2(NUM_REGS),
  parameter int IMM_W    = 19,
  parameter int DATA_W   = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                hold,
  input  logic [1:0]          mode,
  input  logic [RA_W-1:0]     ra,
  input  logic [RA_W-1:0]     rb,
  input  logic [RA_W-1:0]     rc,
  input  logic [IMM_W-1:0]    imm,
  output logic                busy,
  output logic                done,
  output logic [1:0]          phase,
  output logic [NUM_REGS-1:0] rin_onehot,
  output logic [NUM_REGS-1:0] rout_onehot,
  output logic                ba_out,
  output logic                c_out,
  output logic [DATA_W-1:0]   c_sext,
  output logic                zero_out
);

  state_e              r_state;
  mode_e               r_mode;
  logic [RA_W-1:0]     r_ra, r_rb, r_rc;
  logic                r_busy, r_done, r_ba, r_c, r_zero;
  logic [NUM_REGS-1:0] r_rin, r_rout;
  logic [DATA_W-1:0]   r_sext;

  state_e              w_nxt_state;
  mode_e               w_mode;
  logic [RA_W-1:0]     w_ra, w_rb, w_rc;
  logic                w_rd_en, w_wr_en, w_ba, w_c, w_done, w_zero;
  logic [RA_W-1:0]     w_rd_idx, w_wr_idx;
  logic [NUM_REGS-1:0] w_rd_onehot, w_wr_onehot;
  logic [DATA_W-1:0]   w_sext;

  assign w_sext = DATA_W'(rss_sext({{(SEXT_MAX_W-IMM_W){1'b0}}, imm}, IMM_W));

  // Outputs are decoded from the state being entered, so they register on the same edge.
  always_comb begin
    w_nxt_state = r_state;
    w_mode      = r_mode;
    w_ra        = r_ra;
    w_rb        = r_rb;
    w_rc        = r_rc;
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt_state = S_SRC1;
        w_mode      = mode_e'(mode);
        w_ra        = ra;
        w_rb        = rb;
        w_rc        = rc;
      end
      S_SRC1:  w_nxt_state = (r_mode == MODE_BR) ? S_IDLE : S_SRC2;
      S_SRC2:  w_nxt_state = S_DEST;
      default: w_nxt_state = S_IDLE;
    endcase

    w_rd_en  = 1'b0;
    w_rd_idx = w_rb;
    w_wr_en  = 1'b0;
    w_wr_idx = w_ra;
    w_ba     = 1'b0;
    w_c      = 1'b0;
    w_done   = 1'b0;
    w_zero   = 1'b0;
    case (w_nxt_state)
      S_SRC1: begin
        w_rd_en = 1'b1;
        if (w_mode == MODE_BR) begin
          w_rd_idx = w_ra;
          w_done   = 1'b1;
        end else begin
          w_rd_idx = w_rb;
          w_ba     = (w_mode != MODE_R);
        end
      end
      S_SRC2: begin
        if (w_mode == MODE_R) begin
          w_rd_en  = 1'b1;
          w_rd_idx = w_rc;
        end else begin
          w_c = 1'b1;
        end
      end
      S_DEST: begin
        w_done = 1'b1;
        if (w_mode == MODE_ST) begin
          w_rd_en  = 1'b1;
          w_rd_idx = w_ra;
        end else begin
          w_wr_en  = 1'b1;
          w_wr_idx = w_ra;
        end
      end
      default: ;
    endcase

`ifdef RSS_ZERO_REG_EN
    if (w_rd_en && (w_rd_idx == '0)) begin
      w_zero  = 1'b1;
      w_rd_en = 1'b0;
    end
    if (w_wr_en && (w_wr_idx == '0))
      w_wr_en = 1'b0;
`endif
  end

  onehot_decoder #(.NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_rd_dec (
    .i_en     (w_rd_en),
    .i_idx    (w_rd_idx),
    .o_onehot (w_rd_onehot)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_wr_dec (
    .i_en     (w_wr_en),
    .i_idx    (w_wr_idx),
    .o_onehot (w_wr_onehot)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_R;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ba    <= 1'b0;
      r_c     <= 1'b0;
      r_zero  <= 1'b0;
      r_rin   <= '0;
      r_rout  <= '0;
      r_sext  <= '0;
    end else if (hold && (r_state != S_IDLE)) begin
      // Frozen phase: everything holds except done, which must pulse only once.
      r_done <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_mode  <= w_mode;
      r_ra    <= w_ra;
      r_rb    <= w_rb;
      r_rc    <= w_rc;
      r_busy  <= (w_nxt_state != S_IDLE);
      r_done  <= w_done;
      r_ba    <= w_ba;
      r_c     <= w_c;
      r_zero  <= w_zero;
      r_rin   <= w_wr_onehot;
      r_rout  <= w_rd_onehot;
      if ((r_state == S_IDLE) && start)
        r_sext <= w_sext;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign phase       = r_state;
  assign rin_onehot  = r_rin;
  assign rout_onehot = r_rout;
  assign ba_out      = r_ba;
  assign c_out       = r_c;
  assign c_sext      = r_sext;
  assign zero_out    = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_reg_select_sequencer.sv
// tb_reg_select_sequencer: directed scoreboard bench; expected outputs are queued per step and checked after each edge.
`default_nettype none

module tb_reg_select_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        hold;
  logic [1:0]  mode;
  logic [3:0]  ra, rb, rc;
  logic [18:0] imm;
  logic        busy, done, ba_out, c_out, zero_out;
  logic [1:0]  phase;
  logic [15:0] rin_onehot, rout_onehot;
  logic [31:0] c_sext;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [1:0]  phase;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        ba;
    logic        c;
    logic        zero;
    logic [31:0] csext;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp;
  int    n_fail;

  reg_select_sequencer dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .hold        (hold),
    .mode        (mode),
    .ra          (ra),
    .rb          (rb),
    .rc          (rc),
    .imm         (imm),
    .busy        (busy),
    .done        (done),
    .phase       (phase),
    .rin_onehot  (rin_onehot),
    .rout_onehot (rout_onehot),
    .ba_out      (ba_out),
    .c_out       (c_out),
    .c_sext      (c_sext),
    .zero_out    (zero_out)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic b, input logic d, input logic [1:0] ph,
                              input logic [15:0] rin, input logic [15:0] rout,
                              input logic ba, input logic c, input logic z,
                              input logic [31:0] cs);
    exp_t e;
    e.busy = b; e.done = d; e.phase = ph; e.rin = rin; e.rout = rout;
    e.ba = ba; e.c = c; e.zero = z; e.csext = cs;
    return e;
  endfunction

  task automatic check_front();
    exp_t  e;
    exp_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = mk(busy, done, phase, rin_onehot, rout_onehot, ba_out, c_out, zero_out, c_sext);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic step(input string tag, input logic st, input logic hd, input logic cl, input exp_t e);
    start = st;
    hold  = hd;
    clear = cl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    check_front();
  endtask

  task automatic load(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [18:0] i);
    mode = m; ra = a; rb = b; rc = c; imm = i;
  endtask

  initial begin
    clock = 0; clear = 1; start = 0; hold = 0;
    n_cmp = 0; n_fail = 0;
    load(2'b00, 4'd0, 4'd0, 4'd0, 19'd0);

    step("reset",       0, 0, 1, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h0));

    // R-type with start held high throughout: no restart from DEST
    load(2'b00, 4'd3, 4'd5, 4'd9, 19'd0);
    step("r_src1",      1, 0, 0, mk(1,0,2'b01,16'h0,16'h0020,0,0,0,32'h0));
    step("r_src2",      1, 0, 0, mk(1,0,2'b10,16'h0,16'h0200,0,0,0,32'h0));
    step("r_dest",      1, 0, 0, mk(1,1,2'b11,16'h0008,16'h0,0,0,0,32'h0));
    step("r_idle",      0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h0));

    // I-type, negative immediate
    load(2'b01, 4'd7, 4'd2, 4'd0, 19'h40000);
    step("i_src1",      1, 0, 0, mk(1,0,2'b01,16'h0,16'h0004,1,0,0,32'hFFFC0000));
    step("i_src2",      0, 0, 0, mk(1,0,2'b10,16'h0,16'h0,0,1,0,32'hFFFC0000));
    step("i_dest",      0, 0, 0, mk(1,1,2'b11,16'h0080,16'h0,0,0,0,32'hFFFC0000));
    step("i_idle",      0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'hFFFC0000));

    // Branch with start held: second branch only after busy drops
    load(2'b11, 4'd15, 4'd0, 4'd0, 19'h00123);
    step("br_src1",     1, 0, 0, mk(1,1,2'b01,16'h0,16'h8000,0,0,0,32'h00000123));
    step("br_idle",     1, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h00000123));
    step("br2_src1",    1, 0, 0, mk(1,1,2'b01,16'h0,16'h8000,0,0,0,32'h00000123));
    step("br2_idle",    0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h00000123));

    // Store: hold in IDLE has no effect, hold 3 cycles in SRC2, hold once in DEST
    load(2'b10, 4'd4, 4'd1, 4'd0, 19'h7FFFF);
    step("st_src1",     1, 1, 0, mk(1,0,2'b01,16'h0,16'h0002,1,0,0,32'hFFFFFFFF));
    step("st_src2",     0, 0, 0, mk(1,0,2'b10,16'h0,16'h0,0,1,0,32'hFFFFFFFF));
    step("st_hold1",    1, 1, 0, mk(1,0,2'b10,16'h0,16'h0,0,1,0,32'hFFFFFFFF));
    step("st_hold2",    0, 1, 0, mk(1,0,2'b10,16'h0,16'h0,0,1,0,32'hFFFFFFFF));
    step("st_hold3",    0, 1, 0, mk(1,0,2'b10,16'h0,16'h0,0,1,0,32'hFFFFFFFF));
    step("st_dest",     0, 0, 0, mk(1,1,2'b11,16'h0,16'h0010,0,0,0,32'hFFFFFFFF));
    step("st_dest_hld", 0, 1, 0, mk(1,0,2'b11,16'h0,16'h0010,0,0,0,32'hFFFFFFFF));
    step("st_idle",     0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'hFFFFFFFF));

    // Clear on the edge that would enter DEST: no done, c_sext cleared
    load(2'b00, 4'd6, 4'd1, 4'd2, 19'h40000);
    step("clr_src1",    1, 0, 0, mk(1,0,2'b01,16'h0,16'h0002,0,0,0,32'hFFFC0000));
    step("clr_src2",    0, 0, 0, mk(1,0,2'b10,16'h0,16'h0004,0,0,0,32'hFFFC0000));
    step("clr_1",       0, 1, 1, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h0));
    step("clr_2",       1, 0, 1, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h0));
    step("clr_after",   0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h0));

    // R0 handling
    load(2'b00, 4'd0, 4'd0, 4'd1, 19'd5);
`ifdef RSS_ZERO_REG_EN
    step("r0_src1",     1, 0, 0, mk(1,0,2'b01,16'h0,16'h0,0,0,1,32'h5));
    step("r0_src2",     0, 0, 0, mk(1,0,2'b10,16'h0,16'h0002,0,0,0,32'h5));
    step("r0_dest",     0, 0, 0, mk(1,1,2'b11,16'h0,16'h0,0,0,0,32'h5));
`else
    step("r0_src1",     1, 0, 0, mk(1,0,2'b01,16'h0,16'h0001,0,0,0,32'h5));
    step("r0_src2",     0, 0, 0, mk(1,0,2'b10,16'h0,16'h0002,0,0,0,32'h5));
    step("r0_dest",     0, 0, 0, mk(1,1,2'b11,16'h0001,16'h0,0,0,0,32'h5));
`endif
    step("r0_idle",     0, 0, 0, mk(0,0,2'b00,16'h0,16'h0,0,0,0,32'h5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
- Parametrised, sequenced successor to the combinational register select/encode stage in the datapath.
- On a start pulse it latches the register fields, immediate and instruction mode from the IR.
- It then steps through operand phases and emits registered one-hot register read/write enables, a bus-select for the sign-extended constant, and a done pulse.
- It sits between the control unit and the register file / bus mux, and removes per-cycle Gra/Grb/Grc/Rin/Rout sequencing from the control FSM.

Parameters:
- NUM_REGS, 16, number of general registers; must be a power of 2, at least 2.
- RA_W, $clog2(NUM_REGS), register field width (derived; not overridden).
- IMM_W, 19, immediate field width.
- DATA_W, 32, bus width; sign-extension target; DATA_W > IMM_W.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- hold  in  1  freezes the current phase (multi-cycle ALU / memory wait).
- mode  in  2  00 R-type, 01 I-type, 10 store, 11 branch.
- ra, rb, rc  in  RA_W each  register fields from IR.
- imm  in  IMM_W  immediate field from IR.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse on the last phase.
- phase  out  2  current state encoding.
- rin_onehot  out  NUM_REGS  register write enable.
- rout_onehot  out  NUM_REGS  register read enable.
- ba_out  out  1  base-address read qualifier (R0 reads as 0 under BA).
- c_out  out  1  selects c_sext onto the bus.
- c_sext  out  DATA_W  imm sign-extended from bit IMM_W-1; registered at start.
- zero_out  out  1  drive constant 0 on bus (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (clear=1 on a clock edge):
  - state goes to IDLE.
  - All outputs go to 0, including c_sext.
  - Latched fields go to 0.
  - Reset mid-operation aborts with no done pulse.
- State encodings: IDLE=00, SRC1=01, SRC2=10, DEST=11.
- All outputs are registered; they change only on clock edges.
- IDLE:
  - If start=1, latch ra/rb/rc/imm/mode, load c_sext, go to SRC1.
  - start while busy is ignored (no queueing).
- Phase outputs (exactly one enable class active per phase; unlisted outputs are 0):
  - R-type:
    - SRC1: rout = 1<<rb.
    - SRC2: rout = 1<<rc.
    - DEST: rin = 1<<ra, done=1.
  - I-type:
    - SRC1: rout = 1<<rb, ba_out=1.
    - SRC2: c_out=1.
    - DEST: rin = 1<<ra, done=1.
  - Store:
    - SRC1: rout = 1<<rb, ba_out=1.
    - SRC2: c_out=1.
    - DEST: rout = 1<<ra, rin=0, done=1.
  - Branch:
    - SRC1: rout = 1<<ra, done=1.
    - Returns to IDLE next cycle; SRC2/DEST are skipped.
- Latency:
  - start edge to first enable: 1 cycle.
  - R/I/store occupy 3 cycles; branch occupies 1.
  - busy deasserts the cycle after done.
  - Back-to-back: start may be asserted in the cycle busy is 0; there is no same-cycle restart from DEST.
- hold=1 in a non-IDLE state:
  - State and all outputs are frozen.
  - done stays high only if frozen in the done phase, and pulses once per instruction.
  - Specified: done asserts on entry to the final phase and is forced 0 on held cycles after the first.
- hold in IDLE has no effect; start still accepted.
- clear has priority over hold and start.
- Register indices are always in range (RA_W bits); no wrap handling is needed.

Optional Feature:
- Macro: RSS_ZERO_REG_EN.
- Defined (R0 hardwired zero):
  - Any rout to index 0 instead asserts zero_out=1 with rout_onehot=0.
  - rin to index 0 is suppressed (rin_onehot=0).
  - ba_out behaviour is unchanged otherwise.
- Undefined:
  - zero_out is tied 0.
  - R0 is ordinary except the existing ba_out qualifier.

Decomposition:
- Shared package rss_pkg:
  - mode enum (MODE_R, MODE_I, MODE_ST, MODE_BR).
  - state enum (S_IDLE..S_DEST).
  - a sign-extension function parametrised by IMM_W/DATA_W.
- One natural sub-module: onehot_decoder (RA_W in, NUM_REGS out, enable input), instantiated twice (read, write).

Test Plan:
1. Reset: clear=1 for 2 cycles mid-DEST of an R-type -> next cycle busy=0, done=0, rin/rout=0, c_sext=0; no done pulse.
2. R-type, ra=3, rb=5, rc=9, start=1 -> cycle1 rout=0x0020, cycle2 rout=0x0200, cycle3 rin=0x0008 with done=1, cycle4 busy=0.
3. I-type, imm=19'h40000, rb=2, ra=7:
   - c_sext=32'hFFFC0000.
   - SRC1 rout=0x0004 with ba_out=1.
   - SRC2 c_out=1.
   - DEST rin=0x0080 with done=1.
4. Branch, ra=15 -> 1 cycle rout=0x8000 with done=1, then IDLE. start held high during it -> second instruction begins only after busy=0.
5. Store with hold=1 for 3 cycles in SRC2 -> c_out stays 1 for 4 cycles; DEST rout=1<<ra, rin=0, exactly one done.
6. RSS_ZERO_REG_EN defined, R-type ra=0, rb=0 -> SRC1 zero_out=1 with rout=0; DEST rin=0, done=1.
